pc_fetch_ctrl: RTL and testbench

- Program-counter sequencer for the IF stage of the pipelined MIPS core.
- Owns the PC register and computes next-PC by priority: exception vector > branch/jump redirect > hold > PC+4.
- Drives the instruction-memory req/ack handshake and presents fetched instructions to the IF/ID register.
- Buffers one instruction under ID stall and discards in-flight fetches invalidated by a redirect.

---
 rtl/pc_fetch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// Purpose : IF-stage PC sequencer; owns the PC, runs the imem req/ack handshake, feeds IF/ID.
// Latency : first imem_req 1 cycle after reset release; redirect reaches imem_addr next cycle when idle.
// Backpr. : ID stall parks one fetched instruction in a hold buffer and stops issuing requests.
//
// Optional feature macro: PC_ALIGN_CHECK_EN (adds the misalign port; misaligned
// redirects are converted to an exception to EXC_VECTOR).
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   stall                             IF/ID cannot accept this cycle
//   redirect_valid, redirect_target   branch/jump redirect from EX
//   exc_valid                         exception/interrupt taken (beats redirect)
//   imem_req, imem_addr               fetch request toward instruction memory
//   imem_ack, imem_rdata              fetch completion and data
//   if_valid, if_instr, if_pc, if_pc_plus4   instruction toward IF/ID
//   misalign                          (PC_ALIGN_CHECK_EN only) misaligned-redirect pulse
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] pend, pend_nxt;
  logic [31:0] hold_instr, hold_instr_nxt;
  logic        hold_vld, hold_vld_nxt;

  // Event decode: exception beats redirect; tgt is the destination of whichever wins.
  logic        evt;
  logic        redir_mis;
  logic [31:0] tgt;

`ifdef PC_ALIGN_CHECK_EN
  assign redir_mis = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign tgt       = (exc_valid || redir_mis) ? EXC_VECTOR : redirect_target;
`else
  assign redir_mis = 1'b0;
  // Low bits are cleared rather than trusted: the core only fetches word-aligned.
  assign tgt       = exc_valid ? EXC_VECTOR : (redirect_target & 32'hFFFF_FFFC);
`endif

  assign evt = exc_valid | redirect_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      pend       <= RESET_VECTOR;
      hold_instr <= 32'd0;
      hold_vld   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend       <= pend_nxt;
      hold_instr <= hold_instr_nxt;
      hold_vld   <= hold_vld_nxt;
    end
  end

  // Next-state / next-data logic
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_nxt       = pend;
    hold_instr_nxt = hold_instr;
    hold_vld_nxt   = hold_vld;
    unique case (state)
      IDLE: begin
        // Events are ignored here; fetching always starts from the current pc.
        state_nxt = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          if (evt) begin
            // Response belongs to the abandoned path; refetch from the target.
            pc_nxt = tgt;
          end else if (!stall) begin
            pc_nxt = pc + 32'd4;
          end else begin
            hold_instr_nxt = imem_rdata;
            hold_vld_nxt   = 1'b1;
            state_nxt      = HOLD;
          end
        end else if (evt) begin
          // Address must stay stable until ack, so park the target and flush the fetch.
          pend_nxt  = tgt;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          pc_nxt    = evt ? tgt : pend;
          state_nxt = REQ;
        end else if (evt) begin
          pend_nxt = tgt;
        end
      end
      HOLD: begin
        if (evt) begin
          pc_nxt       = tgt;
          hold_vld_nxt = 1'b0;
          state_nxt    = REQ;
        end else if (!stall) begin
          pc_nxt       = pc + 32'd4;
          hold_vld_nxt = 1'b0;
          state_nxt    = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    if_valid = 1'b0;
    if_instr = 32'd0;
    unique case (state)
      REQ: begin
        imem_req = 1'b1;
        if_valid = imem_ack && !evt;
        if_instr = imem_rdata;
      end
      DROP: begin
        imem_req = 1'b1;
      end
      HOLD: begin
        if_valid = hold_vld;
        if_instr = hold_instr;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // Pulses in the cycle the misaligned redirect is taken; a real exception masks it.
  assign misalign = (state != IDLE) && redir_mis && !exc_valid;
`endif

  assign imem_addr   = pc;
  assign if_pc       = pc;
  assign if_pc_plus4 = pc + 32'd4;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Purpose : randomized scoreboard bench for pc_fetch_ctrl against a transaction-level model.
// Latency : expectations for a cycle are queued right after the edge and checked at the falling edge.
// Backpr. : stall, ack gaps, redirects and exceptions are randomized with varying densities per phase.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        exc_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .exc_valid       (exc_valid),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign        (misalign)
`endif
  );

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        mis;
  } cyc_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } cons_t;

  cyc_t  cyc_q[$];
  cons_t cons_q[$];
  bit    running = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a fetch is either not yet started, outstanding (fresh or
  // stale after a redirect), or completed and held for a stalled ID stage.
  logic [31:0] m_pc, m_pend, m_hold;
  bit          m_idle, m_out, m_stale, m_held;

  task automatic model_reset();
    m_pc = RV; m_pend = RV; m_hold = 32'd0;
    m_idle = 1'b1; m_out = 1'b0; m_stale = 1'b0; m_held = 1'b0;
  endtask

  // One cycle of stimulus: inputs are driven just after the rising edge.
  task automatic step(input int p_stall, input int p_rv, input int p_exc, input int p_ack);
    logic        evt;
    logic        mis;
    logic [31:0] tgt;
    logic [31:0] rnd;
    cyc_t        e;
    rnd             = $urandom();
    stall           = ($urandom_range(0, 99) < p_stall);
    redirect_valid  = ($urandom_range(0, 99) < p_rv);
    exc_valid       = ($urandom_range(0, 99) < p_exc);
    imem_rdata      = $urandom();
    imem_ack        = m_out && ($urandom_range(0, 99) < p_ack);
    case ($urandom_range(0, 5))
      0:       redirect_target = 32'h0040_0020;
      1:       redirect_target = 32'h0040_0022;
      2:       redirect_target = 32'hFFFF_FFF8;
      3:       redirect_target = 32'hFFFF_FFFC;
      4:       redirect_target = rnd & 32'hFFFF_FFFC;
      default: redirect_target = rnd;
    endcase

    evt = exc_valid | redirect_valid;
`ifdef PC_ALIGN_CHECK_EN
    mis = redirect_valid && ((redirect_target & 32'h3) != 32'd0);
    tgt = (exc_valid || mis) ? EV : redirect_target;
`else
    mis = 1'b0;
    tgt = exc_valid ? EV : (redirect_target & 32'hFFFF_FFFC);
`endif

    e.req  = m_out;
    e.addr = m_pc;
    e.vld  = (m_out && !m_stale && imem_ack && !evt) || m_held;
    e.mis  = !m_idle && mis && !exc_valid;
    cyc_q.push_back(e);

    if (m_idle) begin
      m_idle = 1'b0;
      m_out  = 1'b1;
    end else if (m_held) begin
      if (evt) begin
        m_held = 1'b0; m_out = 1'b1; m_pc = tgt;
      end else if (!stall) begin
        cons_q.push_back('{pc: m_pc, instr: m_hold});
        m_held = 1'b0; m_out = 1'b1; m_pc = m_pc + 32'd4;
      end
    end else if (m_stale) begin
      if (imem_ack) begin
        m_pc = evt ? tgt : m_pend;
        m_stale = 1'b0;
      end else if (evt) begin
        m_pend = tgt;
      end
    end else if (m_out) begin
      if (imem_ack) begin
        if (evt) begin
          m_pc = tgt;
        end else if (!stall) begin
          cons_q.push_back('{pc: m_pc, instr: imem_rdata});
          m_pc = m_pc + 32'd4;
        end else begin
          m_hold = imem_rdata; m_held = 1'b1; m_out = 1'b0;
        end
      end else if (evt) begin
        m_stale = 1'b1;
        m_pend  = tgt;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    running        = 1'b0;
    rst_n          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    exc_valid      = 1'b0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_imem_addr", imem_addr, RV);
    chk("rst_if_pc", if_pc, RV);
    chk("rst_if_pc_plus4", if_pc_plus4, RV + 32'd4);
`ifdef PC_ALIGN_CHECK_EN
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    running = 1'b1;
  endtask

  // Monitor: per-cycle handshake outputs, plus content of every consumed instruction.
  always @(negedge clk) begin
    cyc_t  e;
    cons_t c;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
      if (e.req) chk("imem_addr", imem_addr, e.addr);
      chk("if_valid", {31'd0, if_valid}, {31'd0, e.vld});
`ifdef PC_ALIGN_CHECK_EN
      chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
    end
    if (running && if_valid === 1'b1 && !stall && !exc_valid && !redirect_valid) begin
      if (cons_q.size() == 0) begin
        chk("spurious_consume", {31'd0, if_valid}, 32'd0);
      end else begin
        c = cons_q.pop_front();
        chk("if_pc", if_pc, c.pc);
        chk("if_instr", if_instr, c.instr);
        chk("if_pc_plus4", if_pc_plus4, c.pc + 32'd4);
      end
    end
  end

  initial begin
    do_reset();
    // Streaming: acks every cycle, no stalls or events.
    repeat (40) step(0, 0, 0, 100);
    // Stall-heavy with slow memory.
    repeat (1500) step(50, 5, 1, 40);
    chk("leftover_consumes_p1", cons_q.size(), 32'd0);
    do_reset();
    // Redirect/exception heavy.
    repeat (1500) step(25, 25, 8, 50);
    chk("leftover_consumes_p2", cons_q.size(), 32'd0);
    do_reset();
    // Mixed traffic.
    repeat (2000) step(30, 12, 4, 60);
    @(negedge clk);
    chk("leftover_consumes_p3", cons_q.size(), 32'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
